// File: rtl/lvds_align_ctrl.sv
// lvds_align_ctrl: bitslip word-alignment FSM for a 7:1 LVDS clock lane
module lvds_align_ctrl #(
  parameter logic [6:0] CLK_PATTERN   = 7'b1100011,
  parameter int          LOCK_CNT      = 16,
  parameter int          SETTLE_CYCLES = 4,
  parameter int          LOSS_CNT      = 3
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       EN_I,
  input  logic [6:0] CLK_LANE_I,
  output logic       BITSLIP_O,
  output logic       ALIGNED_O,
  output logic       ALIGN_ERR_O,
  output logic [2:0] SLIP_CNT_O,
  output logic       LOCK_LOST_O,
  output logic [2:0] STATE_O
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] M_LAST = MW'(LOCK_CNT - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LOSS_CNT - 1);
  typedef enum logic [2:0] {IDLE = 3'd0, CHECK = 3'd1, SLIP = 3'd2, SETTLE = 3'd3, LOCKED = 3'd4, FAIL = 3'd5} state_t;
  state_t state;
  logic [MW-1:0] match_cnt;
  logic [SW-1:0] settle_cnt;
  logic [LW-1:0] loss_cnt;
  logic hit;
  assign hit = CLK_LANE_I == CLK_PATTERN;
  assign STATE_O = state;
  // alignment FSM; every output is a flop loaded alongside the state it belongs to
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state       <= IDLE;
      match_cnt   <= '0;
      settle_cnt  <= '0;
      loss_cnt    <= '0;
      SLIP_CNT_O  <= '0;
      BITSLIP_O   <= 1'b0;
      ALIGNED_O   <= 1'b0;
      ALIGN_ERR_O <= 1'b0;
      LOCK_LOST_O <= 1'b0;
    end else begin
      BITSLIP_O   <= 1'b0;
      ALIGNED_O   <= 1'b0;
      ALIGN_ERR_O <= 1'b0;
      LOCK_LOST_O <= 1'b0;
      if (!EN_I) begin
        state      <= IDLE;
        match_cnt  <= '0;
        settle_cnt <= '0;
        loss_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state      <= CHECK;
            match_cnt  <= '0;
            SLIP_CNT_O <= '0;
          end
          CHECK: begin
            if (hit) begin
              match_cnt <= match_cnt + 1'b1;
              if (match_cnt == M_LAST) begin
                state     <= LOCKED;
                loss_cnt  <= '0;
                ALIGNED_O <= 1'b1;
              end
            end else if (SLIP_CNT_O != 3'd6) begin
              state      <= SLIP;
              match_cnt  <= '0;
              SLIP_CNT_O <= SLIP_CNT_O + 3'd1;
              BITSLIP_O  <= 1'b1;
            end else begin
              state       <= FAIL;
              match_cnt   <= '0;
              ALIGN_ERR_O <= 1'b1;
            end
          end
          SLIP: begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
          SETTLE: begin
            if (settle_cnt == S_LAST) begin
              state     <= CHECK;
              match_cnt <= '0;
            end else
              settle_cnt <= settle_cnt + 1'b1;
          end
          LOCKED: begin
            if (hit) begin
              loss_cnt  <= '0;
              ALIGNED_O <= 1'b1;
            end else if (loss_cnt == L_LAST) begin
              state       <= CHECK;
              match_cnt   <= '0;
              loss_cnt    <= '0;
              SLIP_CNT_O  <= '0;
              LOCK_LOST_O <= 1'b1;
            end else begin
              loss_cnt  <= loss_cnt + 1'b1;
              ALIGNED_O <= 1'b1;
            end
          end
          FAIL: ALIGN_ERR_O <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
